mlp_seq_ctrl: RTL and testbench

Sequenced, resource-shared implementation of the 4-4-2 linear MLP. A single signed multiply-accumulate unit is time-multiplexed across all 24 products: 16 for the hidden layer and 8 for the output layer. The block latches one job (inputs plus both weight sets) on in_ready, runs layer 1 then layer 2, and publishes out0/out1 with per-output ready flags. It is the area-reduced alternative to the fully parallel top-level datapath.

---
 rtl/mlp_pkg.sv | 34 +++
 rtl/mlp_seq_ctrl_if.sv | 25 ++
 rtl/mlp_mac.sv | 31 +++
 rtl/mlp_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_mlp_seq_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared constants, FSM state type and job payload for the sequenced 4-4-2 MLP.
package mlp_pkg;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_HID  = 4;
  localparam int unsigned N_OUT  = 2;
  localparam int unsigned DATA_W = 5;
  localparam int unsigned HID_W  = 12;
  localparam int unsigned OUT_W  = 17;

  localparam int unsigned X_BITS  = N_IN * DATA_W;
  localparam int unsigned W1_BITS = N_IN * N_HID * DATA_W;
  localparam int unsigned W2_BITS = N_HID * N_OUT * DATA_W;

  localparam int unsigned N_STEP = N_IN * N_HID + N_HID * N_OUT;
  localparam int unsigned STEP_W = $clog2(N_STEP);

  localparam logic [STEP_W-1:0] STEP_L1_LAST = STEP_W'(N_IN * N_HID - 1);
  localparam logic [STEP_W-1:0] STEP_OUT0    = STEP_W'(N_IN * N_HID + N_HID - 1);
  localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(N_STEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2
  } state_e;

  typedef struct packed {
    logic [W2_BITS-1:0] w2;
    logic [W1_BITS-1:0] w1;
    logic [X_BITS-1:0]  x;
  } job_t;

endpackage

// File: rtl/mlp_seq_ctrl_if.sv
// Job / result bundle between a job source and the sequenced MLP.
interface mlp_seq_ctrl_if;
  import mlp_pkg::*;

  logic                           in_ready;
  logic [X_BITS-1:0]              x_in;
  logic [W1_BITS-1:0]             w1_in;
  logic [W2_BITS-1:0]             w2_in;
  logic                           busy;
  logic signed [OUT_W-1:0]        out0;
  logic signed [OUT_W-1:0]        out1;
  logic                           out0_ready;
  logic                           out1_ready;

  modport master (
    output in_ready, x_in, w1_in, w2_in,
    input  busy, out0, out1, out0_ready, out1_ready
  );

  modport slave (
    input  in_ready, x_in, w1_in, w2_in,
    output busy, out0, out1, out0_ready, out1_ready
  );

endinterface

// File: rtl/mlp_mac.sv
// Shared signed multiply-accumulate; sum_c exposes acc+product so a final step can store it.
module mlp_mac
  import mlp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [HID_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [OUT_W-1:0] sum_c
);

  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] prod_c;

  // Operand ranges keep the full product inside OUT_W.
  assign prod_c = OUT_W'(a) * OUT_W'(b);
  assign sum_c  = acc_q + prod_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum_c;
    end
  end

endmodule

// File: rtl/mlp_seq_ctrl.sv
// Sequenced 4-4-2 MLP: one MAC time-shared over 16 hidden + 8 output products per job.
// Optional MLP_SEQ_RELU_EN clamps negative hidden neurons to zero before storage.
module mlp_seq_ctrl
  import mlp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mlp_seq_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_q;
  job_t                 job_q;
  logic signed [HID_W-1:0] hidden_q [N_HID];

  logic                 busy_q, out0_ready_q, out1_ready_q;
  logic signed [OUT_W-1:0] out0_q, out1_q;

  logic load_c, mac_en_c, mac_clr_c, hid_we_c, out0_we_c, out1_we_c;

  logic signed [DATA_W-1:0] x_sel_c, w1_sel_c, w2_sel_c, mac_b_c;
  logic signed [HID_W-1:0]  mac_a_c, hid_raw_c, hid_val_c;
  logic signed [OUT_W-1:0]  mac_sum_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_ready)           state_d = L1;
      L1:      if (step_q == STEP_L1_LAST) state_d = L2;
      L2:      if (step_q == STEP_LAST)    state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Control strobes; a group of four products ends on step[1:0]==3
  always_comb begin
    load_c    = 1'b0;
    mac_en_c  = 1'b0;
    mac_clr_c = 1'b0;
    hid_we_c  = 1'b0;
    out0_we_c = 1'b0;
    out1_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_c    = bus.in_ready;
        mac_clr_c = bus.in_ready;
      end
      L1: begin
        mac_en_c  = 1'b1;
        mac_clr_c = (step_q[1:0] == 2'd3);
        hid_we_c  = (step_q[1:0] == 2'd3);
      end
      L2: begin
        mac_en_c  = 1'b1;
        mac_clr_c = (step_q[1:0] == 2'd3);
        out0_we_c = (step_q == STEP_OUT0);
        out1_we_c = (step_q == STEP_LAST);
      end
      default: ;
    endcase
  end

  // Operand select: in L1 step=4j+i walks w1 slots directly; in L2 step-16=4k+j walks w2
  always_comb begin
    x_sel_c  = job_q.x[32'(step_q[1:0]) * DATA_W +: DATA_W];
    w1_sel_c = job_q.w1[32'(step_q[3:0]) * DATA_W +: DATA_W];
    w2_sel_c = job_q.w2[32'(step_q[2:0]) * DATA_W +: DATA_W];
    if (state_q == L2) begin
      mac_a_c = hidden_q[step_q[1:0]];
      mac_b_c = w2_sel_c;
    end else begin
      mac_a_c = HID_W'(x_sel_c);
      mac_b_c = w1_sel_c;
    end
  end

  mlp_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .a     (mac_a_c),
    .b     (mac_b_c),
    .sum_c (mac_sum_c)
  );

  // Hidden neuron value to store; truncation is lossless for all 5-bit operands
  always_comb begin
    hid_raw_c = HID_W'(mac_sum_c);
`ifdef MLP_SEQ_RELU_EN
    hid_val_c = hid_raw_c[HID_W-1] ? '0 : hid_raw_c;
`else
    hid_val_c = hid_raw_c;
`endif
  end

  // Step counter and job/hidden storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      job_q  <= '0;
      for (int n = 0; n < int'(N_HID); n++) hidden_q[n] <= '0;
    end else begin
      if (load_c) begin
        step_q <= '0;
        job_q  <= {bus.w2_in, bus.w1_in, bus.x_in};
      end else if (state_q != IDLE) begin
        step_q <= (step_q == STEP_LAST) ? '0 : step_q + STEP_W'(1);
      end
      if (hid_we_c) hidden_q[step_q[3:2]] <= hid_val_c;
    end
  end

  // Result registers; out0/out1 hold their value across a new accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= 1'b0;
      out0_ready_q <= 1'b0;
      out1_ready_q <= 1'b0;
      out0_q       <= '0;
      out1_q       <= '0;
    end else begin
      if (load_c) begin
        busy_q       <= 1'b1;
        out0_ready_q <= 1'b0;
        out1_ready_q <= 1'b0;
      end
      if (out0_we_c) begin
        out0_q       <= mac_sum_c;
        out0_ready_q <= 1'b1;
      end
      if (out1_we_c) begin
        out1_q       <= mac_sum_c;
        out1_ready_q <= 1'b1;
        busy_q       <= 1'b0;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out0       = out0_q;
  assign bus.out1       = out1_q;
  assign bus.out0_ready = out0_ready_q;
  assign bus.out1_ready = out1_ready_q;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Directed self-checking bench for mlp_seq_ctrl; expectations honour MLP_SEQ_RELU_EN.
module tb_mlp_seq_ctrl;
  import mlp_pkg::*;

  logic clk;
  logic rst;
  mlp_seq_ctrl_if bus();

  mlp_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int prev0 = 0;
  int prev1 = 0;

  logic [X_BITS-1:0]  v1_x, sat_x, pos_x, relu_x;
  logic [W1_BITS-1:0] v1_w1, sat_w1, pos_w1, relu_w1;
  logic [W2_BITS-1:0] v1_w2, sat_w2, pos_w2, relu_w2;
  int v1_e0, v1_e1, relu_e;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [X_BITS-1:0] pack_x(input int a[4]);
    logic [X_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*DATA_W +: DATA_W] = DATA_W'(a[i]);
    return r;
  endfunction

  function automatic logic [W1_BITS-1:0] pack_w1(input int a[16]);
    logic [W1_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*DATA_W +: DATA_W] = DATA_W'(a[i]);
    return r;
  endfunction

  function automatic logic [W2_BITS-1:0] pack_w2(input int a[8]);
    logic [W2_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*DATA_W +: DATA_W] = DATA_W'(a[i]);
    return r;
  endfunction

  task automatic apply(input logic [X_BITS-1:0] x, input logic [W1_BITS-1:0] w1,
                       input logic [W2_BITS-1:0] w2);
    bus.x_in  = x;
    bus.w1_in = w1;
    bus.w2_in = w2;
  endtask

  // One job from acceptance (edge 0) to completion (edge 24)
  task automatic run_job(input string tag, input logic [X_BITS-1:0] x,
                         input logic [W1_BITS-1:0] w1, input logic [W2_BITS-1:0] w2,
                         input int e0, input int e1);
    apply(x, w1, w2);
    bus.in_ready = 1'b1;
    step_edges(1);
    bus.in_ready = 1'b0;
    check_val({tag, " busy@0"}, int'(bus.busy), 1);
    check_val({tag, " rdy0@0"}, int'(bus.out0_ready), 0);
    check_val({tag, " rdy1@0"}, int'(bus.out1_ready), 0);
    check_val({tag, " out0 held@0"}, int'(bus.out0), prev0);
    step_edges(19);
    check_val({tag, " rdy0@19"}, int'(bus.out0_ready), 0);
    step_edges(1);
    check_val({tag, " rdy0@20"}, int'(bus.out0_ready), 1);
    check_val({tag, " out0@20"}, int'(bus.out0), e0);
    check_val({tag, " rdy1@20"}, int'(bus.out1_ready), 0);
    step_edges(3);
    check_val({tag, " busy@23"}, int'(bus.busy), 1);
    step_edges(1);
    check_val({tag, " rdy1@24"}, int'(bus.out1_ready), 1);
    check_val({tag, " out1@24"}, int'(bus.out1), e1);
    check_val({tag, " busy@24"}, int'(bus.busy), 0);
    prev0 = e0;
    prev1 = e1;
  endtask

  initial begin
    // hidden = (66, 12, 1, -16); out0 = -726, out1 = -348 (ReLU zeroes hidden3: -742, -364)
    v1_x  = pack_x('{4, 2, 4, 1});
    v1_w1 = pack_w1('{10, 3, 5, 0,  1, 2, 1, 0,  -3, -1, 2, 7,  0, 0, 0, -16});
    v1_w2 = pack_w2('{-11, 0, -16, -1,  -6, 4, -16, -1});
`ifdef MLP_SEQ_RELU_EN
    v1_e0 = -742; v1_e1 = -364; relu_e = 0;
`else
    v1_e0 = -726; v1_e1 = -348; relu_e = -57600;
`endif
    sat_x  = {N_IN{5'(-16)}};  sat_w1 = {16{5'(-16)}}; sat_w2 = {8{5'(-16)}};
    pos_x  = {N_IN{5'(15)}};   pos_w1 = {16{5'(15)}};  pos_w2 = {8{5'(15)}};
    relu_x = {N_IN{5'(15)}};   relu_w1 = {16{5'(-16)}}; relu_w2 = {8{5'(15)}};

    rst = 1'b1;
    bus.in_ready = 1'b0;
    apply('0, '0, '0);
    step_edges(2);
    check_val("reset busy", int'(bus.busy), 0);
    check_val("reset out0", int'(bus.out0), 0);
    check_val("reset out1", int'(bus.out1), 0);
    check_val("reset rdy0", int'(bus.out0_ready), 0);
    check_val("reset rdy1", int'(bus.out1_ready), 0);
    rst = 1'b0;
    step_edges(1);

    run_job("vec1", v1_x, v1_w1, v1_w2, v1_e0, v1_e1);
    run_job("neg16", sat_x, sat_w1, sat_w2, -65536, -65536);
    run_job("pos15", pos_x, pos_w1, pos_w2, 54000, 54000);

    // in_ready held high, operands scrambled every cycle of the job
    apply(v1_x, v1_w1, v1_w2);
    bus.in_ready = 1'b1;
    step_edges(1);
    check_val("hold busy@0", int'(bus.busy), 1);
    for (int c = 1; c <= 24; c++) begin
      if (c < 23) begin
        bus.x_in  = X_BITS'($urandom);
        bus.w1_in = W1_BITS'({$urandom, $urandom, $urandom});
        bus.w2_in = W2_BITS'({$urandom, $urandom});
      end else begin
        apply(pos_x, pos_w1, pos_w2);
      end
      step_edges(1);
      if (c == 20) check_val("hold out0@20", int'(bus.out0), v1_e0);
      if (c == 24) begin
        check_val("hold out1@24", int'(bus.out1), v1_e1);
        check_val("hold busy@24", int'(bus.busy), 0);
      end
    end
    step_edges(1);
    bus.in_ready = 1'b0;
    check_val("hold busy@25", int'(bus.busy), 1);
    check_val("hold rdy0@25", int'(bus.out0_ready), 0);
    check_val("hold rdy1@25", int'(bus.out1_ready), 0);
    step_edges(20);
    check_val("hold job2 out0", int'(bus.out0), 54000);
    step_edges(4);
    check_val("hold job2 out1", int'(bus.out1), 54000);
    check_val("hold job2 rdy1", int'(bus.out1_ready), 1);
    prev0 = 54000;
    prev1 = 54000;

    // Asynchronous reset in the middle of a job
    apply(v1_x, v1_w1, v1_w2);
    bus.in_ready = 1'b1;
    step_edges(1);
    bus.in_ready = 1'b0;
    step_edges(10);
    #2 rst = 1'b1;
    #1;
    check_val("midrst busy", int'(bus.busy), 0);
    check_val("midrst out0", int'(bus.out0), 0);
    check_val("midrst out1", int'(bus.out1), 0);
    check_val("midrst rdy0", int'(bus.out0_ready), 0);
    check_val("midrst rdy1", int'(bus.out1_ready), 0);
    step_edges(1);
    rst = 1'b0;
    prev0 = 0;
    prev1 = 0;
    step_edges(1);
    run_job("postrst", v1_x, v1_w1, v1_w2, v1_e0, v1_e1);

    run_job("relu", relu_x, relu_w1, relu_w2, relu_e, relu_e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
